imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the pipelined core and its registered instruction ROM.
- Accepts a byte stream (valid/ready) carrying a 16-bit word-count header followed by little-endian 32-bit instructions.
- Writes each assembled instruction into the instruction memory write port.
- Holds the core in reset (CORE_RESET_N low) until the whole image is stored, then releases it.

Parameters:
- ADDR_SIZE, 10, word-address width of instruction memory; depth = 2**ADDR_SIZE words.
- DATA_SIZE, 32, instruction width; only 32 is supported.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- BYTE_VALID  in  1  BYTE_DATA holds a valid byte.
- BYTE_DATA  in  8  stream byte.
- BYTE_READY  out  1  loader accepts a byte this cycle.
- RELOAD  in  1  request a new load; honoured only in DONE or ERR.
- IWE  out  1  instruction memory write enable, one-cycle pulse.
- IWADDR  out  ADDR_SIZE  instruction memory word address.
- IWDATA  out  DATA_SIZE  instruction memory write data.
- CORE_RESET_N  out  1  active-low reset to the pipelined core.
- DONE  out  1  image fully loaded.
- ERROR  out  1  header count exceeds memory depth.
- WORD_COUNT  out  ADDR_SIZE+1  number of words written so far.

Behaviour:
- Handshake: a byte is accepted at a rising edge where BYTE_VALID=1 and BYTE_READY=1.
- BYTE_READY=1 in HDR_LO, HDR_HI and DATA; 0 in DONE and ERR. It is a registered state decode and does not depend on BYTE_VALID.
- All outputs are registered.
- Reset values: state HDR_LO, BYTE_READY=1, IWE=0, IWADDR=0, IWDATA=0, CORE_RESET_N=0, DONE=0, ERROR=0, WORD_COUNT=0. The byte index, header register and partial word also clear.
- HDR_LO: an accepted byte becomes hdr[7:0]; next state HDR_HI.
- HDR_HI: an accepted byte becomes hdr[15:8]. Next state is chosen on the full 16-bit value {byte, hdr[7:0]}:
  - 0 -> DONE;
  - greater than 2**ADDR_SIZE -> ERR;
  - otherwise -> DATA.
- DATA, byte assembly:
  - A 2-bit byte index selects the lane, little-endian: byte k goes to word[8k+7:8k].
  - On acceptance of lane 3, the next edge sets IWE=1, IWADDR=WORD_COUNT[ADDR_SIZE-1:0] and IWDATA = the assembled word.
  - The WORD_COUNT increment and the byte-index wrap to 0 also happen on that edge.
  - IWE is high for exactly one cycle per word.
- DATA, back-to-back: bytes may arrive every cycle, and the write pulse overlaps reception of the next word without stall.
- DATA exit: when the incremented WORD_COUNT equals hdr, the state goes to DONE in the same edge as the final IWE pulse.
- DONE:
  - DONE=1 and CORE_RESET_N=1 from the cycle after the final IWE pulse. Both are registered from the state, so CORE_RESET_N rises exactly one cycle after the last IWE.
  - IWE=0, and stream bytes are not accepted.
- ERR: ERROR=1, CORE_RESET_N stays 0, IWE never asserted.
- RELOAD in DONE or ERR: next edge goes to HDR_LO with CORE_RESET_N=0, DONE=0, ERROR=0, WORD_COUNT=0. IWADDR and IWDATA hold their last values.
- RELOAD in any other state has no effect.
- RESET mid-load (any state, including the cycle of a lane-3 acceptance): all reset values apply at that edge, the partial word is discarded, and no IWE pulse follows.
- RESET has priority over RELOAD and over byte acceptance.
- hdr = 2**ADDR_SIZE (1024 by default) is legal: addresses 0..1023 are written, and WORD_COUNT reaches 1024 (hence its ADDR_SIZE+1 width).
- Gaps in BYTE_VALID inside a word are allowed; the partial word and byte index are held.

Test Plan:
- Reset, then header 0x02,0x00 and bytes 13,05,A0,00, 93,05,F0,FF with no gaps -> IWE pulses write addr 0 = 0x00A00513 and addr 1 = 0xFFF00593; WORD_COUNT=2; CORE_RESET_N=1 exactly one cycle after the second pulse; BYTE_READY=0.
- Same image with BYTE_VALID low for 3 cycles between every byte -> identical writes and data; no extra IWE pulses.
- Header 0x00,0x00 -> DONE=1 and CORE_RESET_N=1 with no IWE pulse.
- Header 0x01,0x04 (1025) with ADDR_SIZE=10 -> ERROR=1, CORE_RESET_N=0, BYTE_READY=0, no writes. Then RELOAD=1 for one cycle -> back to HDR_LO, ERROR=0, BYTE_READY=1.
- Header 0x03,0x00, one full word, then RESET asserted after the 2nd byte of word 1 -> no second IWE; all outputs at reset values. A fresh 1-word image then loads at addr 0.
- Header 0x00,0x04 (1024) with 4096 bytes of ramp data -> last write at addr 1023, WORD_COUNT=1024, DONE=1. Then RELOAD=1 with a 1-word image -> writes addr 0; CORE_RESET_N low during the reload.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader. Takes a byte stream carrying a 16-bit
// word-count header followed by little-endian 32-bit instructions, writes
// each word into the instruction memory, and holds the core in reset until
// the whole image is stored.
module imem_loader #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 BYTE_VALID,
  input  logic [7:0]           BYTE_DATA,
  output logic                 BYTE_READY,
  input  logic                 RELOAD,
  output logic                 IWE,
  output logic [ADDR_SIZE-1:0] IWADDR,
  output logic [DATA_SIZE-1:0] IWDATA,
  output logic                 CORE_RESET_N,
  output logic                 DONE,
  output logic                 ERROR,
  output logic [ADDR_SIZE:0]   WORD_COUNT
);

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal header: a full memory image.
  localparam logic [16:0]        DEPTH  = 17'(2 ** ADDR_SIZE);
  localparam logic [ADDR_SIZE:0] WC_ONE = 1;

  state_t               state_q, state_d;
  logic [15:0]          hdr_q;
  logic [1:0]           idx_q;
  logic [23:0]          part_q;
  logic [ADDR_SIZE:0]   wc_inc;
  logic [15:0]          hdr_full;
  logic                 accept;
  logic                 last_byte;
  logic                 done_hold;

  // BYTE_READY is a flop that mirrors the state, so it is safe to use
  // directly in the handshake.
  assign accept    = BYTE_VALID & BYTE_READY;
  assign last_byte = accept && (state_q == S_DATA) && (idx_q == 2'd3);
  assign wc_inc    = WORD_COUNT + WC_ONE;
  assign hdr_full  = {BYTE_DATA, hdr_q[7:0]};

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_HDR_LO;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR_LO: if (accept) state_d = S_HDR_HI;
      S_HDR_HI: begin
        if (accept) begin
          if (hdr_full == 16'd0)              state_d = S_DONE;
          else if ({1'b0, hdr_full} > DEPTH)  state_d = S_ERR;
          else                                state_d = S_DATA;
        end
      end
      // Leave on the same edge as the final write pulse.
      S_DATA:   if (last_byte && (16'(wc_inc) == hdr_q)) state_d = S_DONE;
      S_DONE,
      S_ERR:    if (RELOAD) state_d = S_HDR_LO;
      default:  state_d = S_HDR_LO;
    endcase
  end

  // DONE / CORE_RESET_N lag the state by one cycle so the core leaves reset
  // only after the last word has actually been written; a reload drops them
  // on the same edge that leaves DONE.
  assign done_hold = (state_q == S_DONE) && (state_d == S_DONE);

  // Byte assembly, memory write port and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BYTE_READY   <= 1'b1;
      IWE          <= 1'b0;
      IWADDR       <= '0;
      IWDATA       <= '0;
      CORE_RESET_N <= 1'b0;
      DONE         <= 1'b0;
      ERROR        <= 1'b0;
      WORD_COUNT   <= '0;
      hdr_q        <= '0;
      idx_q        <= '0;
      part_q       <= '0;
    end else begin
      IWE          <= 1'b0;
      BYTE_READY   <= (state_d == S_HDR_LO) || (state_d == S_HDR_HI) ||
                      (state_d == S_DATA);
      ERROR        <= (state_d == S_ERR);
      DONE         <= done_hold;
      CORE_RESET_N <= done_hold;
      if (accept) begin
        case (state_q)
          S_HDR_LO: hdr_q[7:0]  <= BYTE_DATA;
          S_HDR_HI: hdr_q[15:8] <= BYTE_DATA;
          S_DATA: begin
            case (idx_q)
              2'd0:    part_q[7:0]   <= BYTE_DATA;
              2'd1:    part_q[15:8]  <= BYTE_DATA;
              2'd2:    part_q[23:16] <= BYTE_DATA;
              default: begin
                IWE        <= 1'b1;
                IWADDR     <= WORD_COUNT[ADDR_SIZE-1:0];
                IWDATA     <= {BYTE_DATA, part_q};
                WORD_COUNT <= wc_inc;
              end
            endcase
            idx_q <= idx_q + 2'd1;
          end
          default: ;
        endcase
      end
      // Reload restarts counting; the write port keeps its last values.
      if (RELOAD && ((state_q == S_DONE) || (state_q == S_ERR))) begin
        WORD_COUNT <= '0;
        idx_q      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed image loads; expected memory writes go into a
// queue and a negedge monitor pops and compares each IWE pulse.
module tb_imem_loader;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RESET, BYTE_VALID, RELOAD;
  logic [7:0]    BYTE_DATA;
  logic          BYTE_READY, IWE, CORE_RESET_N, DONE, ERROR;
  logic [AW-1:0] IWADDR;
  logic [31:0]   IWDATA;
  logic [AW:0]   WORD_COUNT;

  imem_loader #(.ADDR_SIZE(AW), .DATA_SIZE(32)) dut (
    .CLK(CLK), .RESET(RESET), .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA),
    .BYTE_READY(BYTE_READY), .RELOAD(RELOAD), .IWE(IWE), .IWADDR(IWADDR),
    .IWDATA(IWDATA), .CORE_RESET_N(CORE_RESET_N), .DONE(DONE), .ERROR(ERROR),
    .WORD_COUNT(WORD_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t  exp_q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic exp_iwe_before_rise = 1'b1;
  logic prev_iwe = 1'b0;
  logic prev_crn = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: every IWE pulse must match the head of the queue; the core
  // reset release must directly follow the last write (or none for an
  // empty image).
  always @(negedge CLK) begin
    if (IWE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", IWADDR, IWDATA);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(IWADDR), 64'(e.addr));
        check("write_data", 64'(IWDATA), 64'(e.data));
      end
    end
    if (CORE_RESET_N === 1'b1 && prev_crn === 1'b0)
      check("crn_rise_after_iwe", 64'(prev_iwe), 64'(exp_iwe_before_rise));
    prev_iwe <= IWE;
    prev_crn <= CORE_RESET_N;
  end

  // All stimulus starts and ends on a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    BYTE_VALID = 1'b1;
    BYTE_DATA  = b;
    while (BYTE_READY !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) check("byte_ready_timeout", 64'(BYTE_READY), 64'd1);
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic send_hdr(input logic [15:0] h, input int gap);
    send_byte(h[7:0], gap);
    send_byte(h[15:8], gap);
  endtask

  task automatic wait_done();
    int n = 0;
    while (DONE !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("done_seen", 64'(DONE), 64'd1);
  endtask

  task automatic do_reload();
    RELOAD = 1'b1;
    @(negedge CLK);
    RELOAD = 1'b0;
    check("reload_done", 64'(DONE), 64'd0);
    check("reload_crn", 64'(CORE_RESET_N), 64'd0);
    check("reload_wc", 64'(WORD_COUNT), 64'd0);
    check("reload_ready", 64'(BYTE_READY), 64'd1);
    check("reload_error", 64'(ERROR), 64'd0);
  endtask

  task automatic chk_reset_vals();
    check("rst_ready", 64'(BYTE_READY), 64'd1);
    check("rst_iwe", 64'(IWE), 64'd0);
    check("rst_iwaddr", 64'(IWADDR), 64'd0);
    check("rst_iwdata", 64'(IWDATA), 64'd0);
    check("rst_crn", 64'(CORE_RESET_N), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_error", 64'(ERROR), 64'd0);
    check("rst_wc", 64'(WORD_COUNT), 64'd0);
  endtask

  task automatic two_word_image(input int gap);
    exp_q.push_back('{addr: 10'd0, data: 32'h00A00513});
    exp_q.push_back('{addr: 10'd1, data: 32'hFFF00593});
    send_hdr(16'd2, gap);
    send_word(32'h00A00513, gap);
    send_word(32'hFFF00593, gap);
    wait_done();
    check("img2_wc", 64'(WORD_COUNT), 64'd2);
    check("img2_crn", 64'(CORE_RESET_N), 64'd1);
    check("img2_ready", 64'(BYTE_READY), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    RESET = 1'b1; BYTE_VALID = 1'b0; BYTE_DATA = 8'h00; RELOAD = 1'b0;
    repeat (2) @(negedge CLK);
    chk_reset_vals();
    RESET = 1'b0;
    @(negedge CLK);

    // Two-word image, back-to-back bytes.
    two_word_image(0);
    do_reload();
    check("hold_iwaddr", 64'(IWADDR), 64'd1);
    check("hold_iwdata", 64'(IWDATA), 64'hFFF00593);

    // Same image with 3-cycle gaps.
    two_word_image(3);
    do_reload();

    // Empty image: release with no write.
    exp_iwe_before_rise = 1'b0;
    send_hdr(16'd0, 0);
    wait_done();
    check("empty_crn", 64'(CORE_RESET_N), 64'd1);
    check("empty_wc", 64'(WORD_COUNT), 64'd0);
    @(negedge CLK);
    exp_iwe_before_rise = 1'b1;
    do_reload();

    // Oversized header 1025.
    send_hdr(16'd1025, 0);
    @(negedge CLK);
    check("err_error", 64'(ERROR), 64'd1);
    check("err_crn", 64'(CORE_RESET_N), 64'd0);
    check("err_ready", 64'(BYTE_READY), 64'd0);
    do_reload();

    // Reset in the middle of word 1 of a 3-word image.
    exp_q.push_back('{addr: 10'd0, data: 32'h44332211});
    send_hdr(16'd3, 0);
    send_word(32'h44332211, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk_reset_vals();
    repeat (3) @(negedge CLK);
    exp_q.push_back('{addr: 10'd0, data: 32'hDEADBEEF});
    send_hdr(16'd1, 0);
    send_word(32'hDEADBEEF, 0);
    wait_done();
    check("fresh_wc", 64'(WORD_COUNT), 64'd1);
    do_reload();

    // Full-depth image of ramp bytes.
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4*i + k);
      exp_q.push_back('{addr: 10'(i), data: w});
    end
    send_hdr(16'd1024, 0);
    check("full_crn_loading", 64'(CORE_RESET_N), 64'd0);
    for (int i = 0; i < 4096; i++) send_byte(8'(i), 0);
    check("full_crn_last_edge", 64'(CORE_RESET_N), 64'd0);
    wait_done();
    check("full_wc", 64'(WORD_COUNT), 64'd1024);
    check("full_last_addr", 64'(IWADDR), 64'd1023);
    do_reload();

    // Reload with a one-word image.
    exp_q.push_back('{addr: 10'd0, data: 32'h12345678});
    send_hdr(16'd1, 0);
    check("reload_crn_low", 64'(CORE_RESET_N), 64'd0);
    send_word(32'h12345678, 0);
    wait_done();
    check("reload_img_wc", 64'(WORD_COUNT), 64'd1);
    repeat (3) @(negedge CLK);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
